// File: rtl/nios_pio_leds_pwm_pkg.sv
// Shared constants for the NIOS LED/PWM output PIO: register map and field widths.
package nios_pio_leds_pwm_pkg;

    localparam int unsigned ADDR_BITS  = 3;
    localparam int unsigned DATA_BITS  = 32;
    localparam int unsigned CHSEL_BITS = 5;

    localparam logic [ADDR_BITS-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_BITS-1:0] ADDR_OUTSET   = 3'd1;
    localparam logic [ADDR_BITS-1:0] ADDR_OUTCLR   = 3'd2;
    localparam logic [ADDR_BITS-1:0] ADDR_MODE     = 3'd3;
    localparam logic [ADDR_BITS-1:0] ADDR_PRESCALE = 3'd4;
    localparam logic [ADDR_BITS-1:0] ADDR_CHSEL    = 3'd5;
    localparam logic [ADDR_BITS-1:0] ADDR_DUTY     = 3'd6;
    localparam logic [ADDR_BITS-1:0] ADDR_COUNT    = 3'd7;

endpackage

// File: rtl/nios_pio_leds_pwm_if.sv
// Avalon-MM slave bus bundle for the PIO: address, select, write strobe and data paths.
interface nios_pio_leds_pwm_if;
    import nios_pio_leds_pwm_pkg::*;

    logic [ADDR_BITS-1:0] address;
    logic                 chipselect;
    logic                 write_n;
    logic [DATA_BITS-1:0] writedata;
    logic [DATA_BITS-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/nios_pwm_timebase.sv
// PWM timebase: down-counting prescaler that emits a one-cycle tick, and a free-running
// period counter advanced on each tick. wrap marks the tick that ends a period.
module nios_pwm_timebase #(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned PRESCALE_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PRESCALE_BITS-1:0] reload,
    output logic                     tick,
    output logic                     wrap,
    output logic [PWM_BITS-1:0]      count
);

    logic [PRESCALE_BITS-1:0] presc_q;
    logic [PWM_BITS-1:0]      count_q;

    assign tick  = (presc_q == '0);
    assign wrap  = tick && (count_q == '1);
    assign count = count_q;

    // Prescaler reloads only when it reaches zero, so a new reload value waits for the
    // current countdown to finish; the period counter steps once per tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            if (tick) begin
                presc_q <= reload;
                count_q <= count_q + PWM_BITS'(1);
            end else begin
                presc_q <= presc_q - PRESCALE_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/nios_pio_leds_pwm.sv
// Avalon-MM output PIO: WIDTH channels, each a static level or a PWM whose duty is
// shadowed and committed at the period wrap so a pulse is never cut short or stretched.
module nios_pio_leds_pwm
    import nios_pio_leds_pwm_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned PRESCALE_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    nios_pio_leds_pwm_if.slave     bus,
    output logic [WIDTH-1:0]       out_port
);

    logic                     wr_en;
    logic [WIDTH-1:0]         data_q;
    logic [WIDTH-1:0]         mode_q;
    logic [PRESCALE_BITS-1:0] prescale_q;
    logic [CHSEL_BITS-1:0]    chsel_q;
    logic [WIDTH-1:0]         pwm;
    logic [WIDTH-1:0]         out_q;
    logic [PWM_BITS-1:0]      shadow_rd [WIDTH];
    logic [DATA_BITS-1:0]     rdata;
    logic                     tick;
    logic                     wrap;
    logic [PWM_BITS-1:0]      count;
    logic                     unused;

    assign wr_en = bus.chipselect && !bus.write_n;

    // Upper write-data bits and the raw tick have no function at this level.
    assign unused = ^{bus.writedata, tick};

    nios_pwm_timebase #(
        .PWM_BITS      (PWM_BITS),
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_timebase (
        .clk    (clk),
        .reset  (reset),
        .reload (prescale_q),
        .tick   (tick),
        .wrap   (wrap),
        .count  (count)
    );

    // Register file: DATA with atomic set/clear aliases, MODE, PRESCALE and CHSEL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            mode_q     <= '0;
            prescale_q <= '0;
            chsel_q    <= '0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_q     <= bus.writedata[WIDTH-1:0];
                ADDR_OUTSET:   data_q     <= data_q | bus.writedata[WIDTH-1:0];
                ADDR_OUTCLR:   data_q     <= data_q & ~bus.writedata[WIDTH-1:0];
                ADDR_MODE:     mode_q     <= bus.writedata[WIDTH-1:0];
                ADDR_PRESCALE: prescale_q <= bus.writedata[PRESCALE_BITS-1:0];
                ADDR_CHSEL:    chsel_q    <= bus.writedata[CHSEL_BITS-1:0];
                default:       ;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [PWM_BITS-1:0] shadow_q;
        logic [PWM_BITS-1:0] active_q;
        logic                duty_we;

        assign duty_we      = wr_en && (bus.address == ADDR_DUTY) && (chsel_q == CHSEL_BITS'(i));
        assign pwm[i]       = (count < active_q);
        assign shadow_rd[i] = shadow_q;

        // Shadow takes bus writes; active copies the pre-edge shadow on wrap, so a write
        // landing on the wrap edge only takes effect one period later.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_q <= '0;
                active_q <= '0;
            end else begin
                if (duty_we) begin
                    shadow_q <= bus.writedata[PWM_BITS-1:0];
                end
                if (wrap) begin
                    active_q <= shadow_q;
                end
            end
        end
    end

    // Output register selects PWM or static level per channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= (mode_q & pwm) | (~mode_q & data_q);
        end
    end

    assign out_port = out_q;

    // Zero-wait-state read mux; out-of-range channel selects read as zero.
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLR: rdata = DATA_BITS'(data_q);
            ADDR_MODE:     rdata = DATA_BITS'(mode_q);
            ADDR_PRESCALE: rdata = DATA_BITS'(prescale_q);
            ADDR_CHSEL:    rdata = DATA_BITS'(chsel_q);
            ADDR_DUTY: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (chsel_q == CHSEL_BITS'(i)) begin
                        rdata = DATA_BITS'(shadow_rd[i]);
                    end
                end
            end
            ADDR_COUNT:    rdata = DATA_BITS'(count);
            default:       rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;

endmodule

// File: tb/tb_nios_pio_leds_pwm.sv
// Self-checking bench for nios_pio_leds_pwm: directed scenarios plus random bus traffic,
// all compared against a cycle-level behavioural model of the register/PWM rules.
module tb_nios_pio_leds_pwm;

    localparam int NCH  = 8;
    localparam int PMOD = 256;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   out_port;

    nios_pio_leds_pwm_if bus ();

    nios_pio_leds_pwm #(
        .WIDTH         (8),
        .PWM_BITS      (8),
        .PRESCALE_BITS (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int m_data, m_mode, m_presc, m_chsel, m_pc, m_cnt, m_out;
    int m_shadow [NCH];
    int m_active [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = 0; m_mode = 0; m_presc = 0; m_chsel = 0; m_pc = 0; m_cnt = 0; m_out = 0;
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
    endtask

    function automatic int model_read(input int a);
        case (a)
            0, 1, 2: return m_data;
            3:       return m_mode;
            4:       return m_presc;
            5:       return m_chsel;
            6:       return (m_chsel < NCH) ? m_shadow[m_chsel] : 0;
            default: return m_cnt;
        endcase
    endfunction

    // One clock edge of the specified behaviour, using the bus values held at that edge.
    task automatic model_edge();
        bit wr;
        int a, d, nout;
        bit tick, wrap;
        wr   = bus.chipselect && !bus.write_n;
        a    = int'(bus.address);
        d    = int'(bus.writedata);
        nout = 0;
        for (int i = 0; i < NCH; i++) begin
            if ((m_mode >> i) & 1) nout |= ((m_cnt < m_active[i]) ? 1 : 0) << i;
            else                   nout |= ((m_data >> i) & 1) << i;
        end
        tick = (m_pc == 0);
        wrap = tick && (m_cnt == PMOD - 1);
        m_pc = tick ? m_presc : m_pc - 1;
        if (wrap) for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
        if (tick) m_cnt = (m_cnt + 1) % PMOD;
        if (wr) begin
            case (a)
                0: m_data = d & 255;
                1: m_data = (m_data | d) & 255;
                2: m_data = m_data & ~d & 255;
                3: m_mode = d & 255;
                4: m_presc = d & 'hFFFF;
                5: m_chsel = d & 31;
                6: if (m_chsel < NCH) m_shadow[m_chsel] = d & 255;
                default: ;
            endcase
        end
        m_out = nout;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        chk("out_port", 32'(out_port), 32'(m_out));
    endtask

    task automatic wr(input int a, input int d);
        bus.address    = 3'(a);
        bus.writedata  = 32'(d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        cyc();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input int a);
        bus.address = 3'(a);
        #1;
        chk($sformatf("read_addr%0d", a), bus.readdata, 32'(model_read(a)));
    endtask

    task automatic rd_const(input int a, input string tag, input int exp);
        bus.address = 3'(a);
        #1;
        chk(tag, bus.readdata, 32'(exp));
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk(tag, 32'(out_port), 32'd0);
    endtask

    int highs;
    int start;
    bit found;

    initial begin
        reset          = 1'b1;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk("reset_out", 32'(out_port), 32'd0);
        @(negedge clk) reset = 1'b0;

        // Reset in the middle of PWM activity
        wr(0, 'hFF); wr(3, 'h0F); wr(6, 100); wr(5, 1); wr(6, 200);
        repeat (300) cyc();
        async_reset("reset_mid_out");
        for (int a = 0; a < 8; a++) rd_const(a, $sformatf("reset_reg%0d", a), 0);
        @(negedge clk) reset = 1'b0;
        wr(0, 'hA5);
        chk("data_lat_edgeN", 32'(out_port), 32'd0);
        cyc();
        chk("data_lat_edgeN1", 32'(out_port), 32'hA5);

        // Set / clear
        wr(0, 'h0F); wr(1, 'h30); wr(2, 'h03);
        rd_const(0, "setclr_rd0", 'h3C);
        rd_const(1, "setclr_rd1", 'h3C);
        rd_const(2, "setclr_rd2", 'h3C);
        cyc();
        chk("setclr_out", 32'(out_port), 32'h3C);

        // PWM duty 64, then 0
        wr(4, 0); wr(3, 1); wr(5, 0); wr(6, 64);
        repeat (300) cyc();
        highs = 0;
        repeat (PMOD) begin cyc(); highs += int'(out_port[0]); end
        chk("duty64_highs", 32'(highs), 32'd64);
        wr(6, 0);
        repeat (300) cyc();
        highs = 0;
        repeat (PMOD) begin cyc(); highs += int'(out_port[0]); end
        chk("duty0_highs", 32'(highs), 32'd0);

        // Shadowing: DUTY write on the wrap edge
        wr(6, 64);
        repeat (300) cyc();
        found = 1'b0;
        bus.address = 3'd7;
        for (int k = 0; k < 600 && !found; k++) begin
            #1;
            if (bus.readdata == 32'd255) found = 1'b1;
            else cyc();
        end
        chk("wrap_found", 32'(found), 32'd1);
        wr(6, 128);
        highs = 0;
        repeat (PMOD) begin cyc(); highs += int'(out_port[0]); end
        chk("shadow_old_period", 32'(highs), 32'd64);
        highs = 0;
        repeat (PMOD) begin cyc(); highs += int'(out_port[0]); end
        chk("shadow_new_period", 32'(highs), 32'd128);

        // Prescaler = 3: a tick every 4 cycles
        wr(4, 3);
        cyc(); cyc();
        rd(7);
        start = int'(bus.readdata);
        repeat (40) begin cyc(); rd(7); end
        chk("presc3_ticks40", 32'((int'(bus.readdata) - start + PMOD) % PMOD), 32'd10);

        // Rewrite to 1 mid-count: old countdown finishes first
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (m_pc == 3) found = 1'b1;
            else cyc();
        end
        chk("presc_phase_found", 32'(found), 32'd1);
        rd(7);
        start = int'(bus.readdata);
        wr(4, 1);
        repeat (40) begin rd(7); cyc(); end
        rd(7);
        chk("presc1_ticks40", 32'((int'(bus.readdata) - start + PMOD) % PMOD), 32'd19);
        wr(4, 0);

        // Invalid channel select
        wr(5, NCH); wr(6, 'h55);
        rd_const(6, "inv_chan_read", 0);
        wr(5, 0);
        rd_const(6, "inv_chan_ch0", 128);
        rd(6);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int op, a, d;
            op = int'($urandom_range(0, 3));
            if (n == 700) begin
                async_reset("rand_reset_out");
                @(negedge clk) reset = 1'b0;
            end
            if (op == 0) begin
                cyc();
            end else begin
                a = int'($urandom_range(0, 7));
                d = int'($urandom);
                if (a == 4) d = int'($urandom_range(0, 2));
                if (a == 5) d = int'($urandom_range(0, 9));
                wr(a, d);
            end
            rd(int'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
